// File: rtl/alu_pkg.sv
// Shared constants for the bit-serial ALU: opcodes, slice operations and
// FSM state encodings, plus the opcode-to-slice-operation mapping.
package alu_pkg;

    // Opcodes presented on the operand handshake
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // Operations understood by the single-bit slice
    localparam logic [1:0] SL_AND = 2'b00;
    localparam logic [1:0] SL_OR  = 2'b01;
    localparam logic [1:0] SL_SUM = 2'b10;

    // Engine FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // ADD and SUB both run through the adder; the logic ops map one-to-one.
    function automatic logic [1:0] slice_sel(input logic [1:0] opcode);
        logic [1:0] sel;
        case (opcode)
            OP_AND:  sel = SL_AND;
            OP_OR:   sel = SL_OR;
            default: sel = SL_SUM;
        endcase
        return sel;
    endfunction

    // True for the opcodes that propagate a carry chain
    function automatic logic is_arith(input logic [1:0] opcode);
        return opcode[1];
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: full adder with optional B inversion and a 3:1
// result mux selecting AND, OR or SUM. Purely combinational.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       invert_b,
    input  logic       cin,
    input  logic [1:0] sel,
    output logic       res,
    output logic       cout
);

    logic bx;
    logic sum;

    assign bx = b ^ invert_b;

    // Full adder on the (possibly inverted) B bit
    always_comb begin
        sum  = a ^ bx ^ cin;
        cout = (a & bx) | (cin & (a ^ bx));
    end

    // Result mux; the unused encoding yields 0
    always_comb begin
        res = 1'b0;
        case (sel)
            SL_AND:  res = a & bx;
            SL_OR:   res = a | bx;
            SL_SUM:  res = sum;
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_engine.sv
// Bit-serial ALU engine. Operands are accepted in IDLE, processed LSB-first
// through one alu_bit_slice over WIDTH RUN cycles, and the result word with
// carry/overflow/zero flags is held in DONE until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; the
// producer must hold in_valid and its data until the transfer edge, and the
// engine holds out_valid and the result fields stable until out_ready.
module serial_alu_engine
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             slice_res;
    logic             slice_cout;

    // The slice always looks at the current LSBs and the running carry
    alu_bit_slice u_slice (
        .a        (a_sh_q[0]),
        .b        (b_sh_q[0]),
        .invert_b (op_q == OP_SUB),
        .cin      (carry_q),
        .sel      (slice_sel(op_q)),
        .res      (slice_res),
        .cout     (slice_cout)
    );

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            op_q     <= OP_AND;
            count_q  <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            op_q     <= op_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state and datapath update for IDLE / RUN / DONE
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        op_d     = op_q;
        count_d  = count_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    op_d     = op;
                    res_sh_d = '0;
                    count_d  = '0;
                    // SUB is A + ~B + 1: the +1 enters as the initial carry
                    carry_d  = (op == OP_SUB);
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_sh_q >> 1;
                res_sh_d[WIDTH-1] = slice_res;
                carry_d  = is_arith(op_q) & slice_cout;
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
                    // carry_q is the carry into the MSB on this cycle
                    cout_d  = is_arith(op_q) & slice_cout;
                    ovf_d   = is_arith(op_q) & (carry_q ^ slice_cout);
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake and result outputs decoded from registered state
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        result    = res_sh_q;
        cout      = cout_q;
        ovf       = ovf_q;
        // Qualified so the flag only reports a result that is being offered
        zero      = out_valid && (res_sh_q == '0);
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_serial_alu_engine.sv
// Bench for serial_alu_engine at WIDTH = 8, 1 and 32. Directed cases and
// backpressure/reset scenarios run on the 8-bit instance; random
// back-to-back streams run on all three against an arithmetic model.
module tb_serial_alu_engine;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [1:0]  op_s;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [2:0]  irdy;
    logic [2:0]  ovld;
    logic [2:0]  cout_v;
    logic [2:0]  ovf_v;
    logic [2:0]  zero_v;
    logic [7:0]  res8;
    logic [0:0]  res1;
    logic [31:0] res32;
    logic [1:0]  dbg8, dbg1, dbg32;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc;

    serial_alu_engine #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(a_s[7:0]), .b(b_s[7:0]), .op(op_s), .out_valid(ovld[0]),
        .out_ready(ordy[0]), .result(res8), .cout(cout_v[0]), .ovf(ovf_v[0]),
        .zero(zero_v[0]), .dbg_state(dbg8)
    );

    serial_alu_engine #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(a_s[0:0]), .b(b_s[0:0]), .op(op_s), .out_valid(ovld[1]),
        .out_ready(ordy[1]), .result(res1), .cout(cout_v[1]), .ovf(ovf_v[1]),
        .zero(zero_v[1]), .dbg_state(dbg1)
    );

    serial_alu_engine #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(a_s), .b(b_s), .op(op_s), .out_valid(ovld[2]),
        .out_ready(ordy[2]), .result(res32), .cout(cout_v[2]), .ovf(ovf_v[2]),
        .zero(zero_v[2]), .dbg_state(dbg32)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int w_of(input int k);
        case (k)
            0:       return 8;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    function automatic logic [31:0] res_of(input int k);
        case (k)
            0:       return {24'b0, res8};
            1:       return {31'b0, res1};
            default: return res32;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: modulo-2^w arithmetic with signed overflow from operand signs
    task automatic model(input int w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic c, output logic v, output logic z);
        longint unsigned m, am, bm, s;
        bit sa, sb, sr;
        m  = (64'd1 << w) - 64'd1;
        am = longint'(a) & m;
        bm = longint'(b) & m;
        case (op)
            2'b00:   s = am & bm;
            2'b01:   s = am | bm;
            2'b10:   s = am + bm;
            default: s = am + (~bm & m) + 64'd1;
        endcase
        r  = 32'(s & m);
        c  = op[1] ? 1'((s >> w) & 64'd1) : 1'b0;
        sa = 1'((am >> (w - 1)) & 64'd1);
        sb = 1'((bm >> (w - 1)) & 64'd1);
        sr = 1'(((s & m) >> (w - 1)) & 64'd1);
        if (op == 2'b10)      v = (sa == sb) && (sr != sa);
        else if (op == 2'b11) v = (sa != sb) && (sr != sa);
        else                  v = 1'b0;
        z  = (r == 32'd0);
    endtask

    // Present an operation and return just after the accepting edge
    task automatic start_op(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input string tag);
        int n;
        a_s = a; b_s = b; op_s = op; iv[k] = 1'b1;
        n = 0;
        while (!irdy[k] && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_in_ready"}, 32'(irdy[k]), 32'd1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        iv[k] = 1'b0;
        a_s = $urandom; b_s = $urandom; op_s = 2'($urandom_range(0, 3));
    endtask

    // Wait (bounded) for out_valid, then check latency and the result fields
    task automatic wait_done(input int k, input logic [31:0] er, input logic ec, input logic ev,
                             input logic ez, input string tag);
        int n;
        n = 0;
        while (!ovld[k] && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(w_of(k)));
        chk({tag, "_result"}, res_of(k), er);
        chk({tag, "_cout"}, 32'(cout_v[k]), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf_v[k]), 32'(ev));
        chk({tag, "_zero"}, 32'(zero_v[k]), 32'(ez));
    endtask

    task automatic run_op(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ec, input logic ev, input logic ez,
                          input string tag);
        start_op(k, op, a, b, tag);
        wait_done(k, er, ec, ev, ez, tag);
    endtask

    task automatic random_stream(input int k, input int nops);
        int acc [$];
        logic [31:0] ra, rb, er;
        logic [1:0]  rop;
        logic        ec, ev, ez;
        for (int i = 0; i < nops; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i == 0) rb = ra;   // exercises the zero flag on SUB/AND-free paths
            model(w_of(k), rop, ra, rb, er, ec, ev, ez);
            run_op(k, rop, ra, rb, er, ec, ev, ez, $sformatf("rnd_w%0d_%0d", w_of(k), i));
            acc.push_back(acc_cyc);
        end
        for (int i = 1; i < acc.size(); i++) begin
            chk($sformatf("period_w%0d_%0d", w_of(k), i), 32'(acc[i] - acc[i-1]), 32'(w_of(k) + 2));
        end
    endtask

    initial begin
        logic [31:0] held;
        rst_n = 1'b0;
        iv    = 3'b000;
        ordy  = 3'b111;
        a_s   = '0; b_s = '0; op_s = 2'b00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(irdy[0]), 32'd1);
        chk("rst_out_valid", 32'(ovld[0]), 32'd0);
        chk("rst_result", res_of(0), 32'd0);
        chk("rst_flags", {29'd0, cout_v[0], ovf_v[0], zero_v[0]}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed 8-bit cases
        run_op(0, 2'b10, 32'h0F, 32'h01, 32'h10, 1'b0, 1'b0, 1'b0, "add_0f_01");
        run_op(0, 2'b11, 32'h00, 32'h01, 32'hFF, 1'b0, 1'b0, 1'b0, "sub_00_01");
        run_op(0, 2'b11, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b1, 1'b0, "sub_80_01");
        run_op(0, 2'b11, 32'h55, 32'h55, 32'h00, 1'b1, 1'b0, 1'b1, "sub_55_55");
        run_op(0, 2'b10, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b1, 1'b0, "add_7f_01");
        run_op(0, 2'b10, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b0, 1'b1, "add_ff_01");
        run_op(0, 2'b00, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, 1'b0, "and_f0_3c");
        run_op(0, 2'b01, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 1'b0, "or_f0_0f");
        @(posedge clk); #1;

        // Backpressure: hold out_ready low 5 cycles with a new request pending
        ordy[0] = 1'b0;
        run_op(0, 2'b10, 32'h3C, 32'h0A, 32'h46, 1'b0, 1'b0, 1'b0, "bp_add");
        held = res_of(0);
        a_s = 32'h10; b_s = 32'h20; op_s = 2'b11; iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_valid_%0d", i), 32'(ovld[0]), 32'd1);
            chk($sformatf("bp_result_%0d", i), res_of(0), 32'h46);
            chk($sformatf("bp_in_ready_%0d", i), 32'(irdy[0]), 32'd0);
        end
        chk("bp_result_stable", res_of(0), held);
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_after_hs_valid", 32'(ovld[0]), 32'd0);
        chk("bp_after_hs_in_ready", 32'(irdy[0]), 32'd1);
        @(posedge clk); #1;
        chk("bp_accepted_next", 32'(irdy[0]), 32'd0);
        iv[0] = 1'b0;
        wait_done(0, 32'hF0, 1'b0, 1'b0, 1'b0, "bp_sub");
        @(posedge clk); #1;

        // Asynchronous reset in the middle of RUN (count = 3)
        start_op(0, 2'b10, 32'hAA, 32'h33, "rst_mid");
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", 32'(irdy[0]), 32'd1);
        chk("async_rst_out_valid", 32'(ovld[0]), 32'd0);
        chk("async_rst_result", res_of(0), 32'd0);
        chk("async_rst_flags", {29'd0, cout_v[0], ovf_v[0], zero_v[0]}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, 2'b10, 32'h01, 32'h01, 32'h02, 1'b0, 1'b0, 1'b0, "post_rst_add");

        // Random back-to-back streams, out_ready tied high
        random_stream(0, 4);
        random_stream(1, 4);
        random_stream(2, 4);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
